// File: rtl/spi_flash_pkg.sv
// spi_flash_pkg: command opcodes and FSM state type shared by the SPI flash responder and loader
package spi_flash_pkg;
    localparam logic [7:0] CMD_FAST_RD = 8'h0B;
    localparam logic [7:0] CMD_RLS_DPD = 8'hAB;
    localparam logic [7:0] CMD_DPD     = 8'hB9;
    typedef enum logic [2:0] {ST_IDLE, ST_CMD, ST_ADDR, ST_DUMMY, ST_DATA, ST_IGNORE} state_t;
endpackage

// File: rtl/spi_edge_sync.sv
// spi_edge_sync: 2-flop synchronizers for CSS/SCK/MOSI plus clk-domain edge strobes
// Ports: css/sck/mosi raw pins in; css_s/mosi_s synchronized levels;
//        sck_rise/sck_fall/css_fall single-cycle edge strobes.
module spi_edge_sync (
    input  logic clk,
    input  logic resetn,
    input  logic css,
    input  logic sck,
    input  logic mosi,
    output logic css_s,
    output logic mosi_s,
    output logic sck_rise,
    output logic sck_fall,
    output logic css_fall
);
    logic [2:0] s1, s2;
    logic [1:0] d;
    always_ff @(posedge clk or negedge resetn)
        if (!resetn) begin
            s1 <= '1;
            s2 <= '1;
            d  <= '1;
        end else begin
            s1 <= {css, sck, mosi};
            s2 <= s1;
            d  <= s2[2:1];
        end
    assign css_s    = s2[2];
    assign mosi_s   = s2[0];
    assign sck_rise = s2[1] & ~d[0];
    assign sck_fall = ~s2[1] & d[0];
    assign css_fall = ~s2[2] & d[1];
endmodule

// File: rtl/spi_flash_responder.sv
// spi_flash_responder: SPI mode-3 flash read responder (FAST_RD 0x0B) backed by a byte-fetch port
// Ports: clk/resetn (async, active-low); i_spi_css/i_spi_clk/i_spi_mosi SPI pins in;
//        o_spi_miso/o_spi_miso_oe SPI data out; o_rd_req/o_rd_addr fetch request;
//        i_rd_data/i_rd_valid fetch completion; o_busy frame active; o_dpd deep power-down;
//        o_underrun sticky late-fetch flag.
// Optional feature: define SPI_RESP_DPD_EN to enable deep power-down (0xB9) / release (0xAB).
module spi_flash_responder
    import spi_flash_pkg::*;
#(
    parameter int DUMMY_CYCLES = 8,
    parameter int MEM_AW       = 24
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              i_spi_css,
    input  logic              i_spi_clk,
    input  logic              i_spi_mosi,
    output logic              o_spi_miso,
    output logic              o_spi_miso_oe,
    output logic              o_rd_req,
    output logic [MEM_AW-1:0] o_rd_addr,
    input  logic [7:0]        i_rd_data,
    input  logic              i_rd_valid,
    output logic              o_busy,
    output logic              o_dpd,
    output logic              o_underrun
);
    logic        css_s, mosi_s, sck_rise, sck_fall, css_fall;
    state_t      state, state_n;
    logic [7:0]  cnt, cmd, tx, rbuf;
    logic [22:0] sh;
    logic [23:0] addr_full;
    logic [2:0]  bcnt;
    logic        rbuf_vld, pend, go_rd, cmd_done, addr_done, dummy_done;

    spi_edge_sync u_sync (
        .clk      (clk),
        .resetn   (resetn),
        .css      (i_spi_css),
        .sck      (i_spi_clk),
        .mosi     (i_spi_mosi),
        .css_s    (css_s),
        .mosi_s   (mosi_s),
        .sck_rise (sck_rise),
        .sck_fall (sck_fall),
        .css_fall (css_fall)
    );

    // The bit arriving on this rise completes the byte/address, so fold it in directly.
    assign cmd        = {sh[6:0], mosi_s};
    assign addr_full  = {sh, mosi_s};
    assign cmd_done   = sck_rise && state == ST_CMD && cnt == 8'd7;
    assign addr_done  = sck_rise && state == ST_ADDR && cnt == 8'd23;
    assign dummy_done = sck_rise && state == ST_DUMMY && cnt == 8'(DUMMY_CYCLES - 1);

`ifdef SPI_RESP_DPD_EN
    logic dpd, wake_p, sleep_p;
    // Power-state commands are latched mid-frame and applied on the frame's closing CSS rise.
    always_ff @(posedge clk or negedge resetn)
        if (!resetn) begin
            dpd     <= 1'b0;
            wake_p  <= 1'b0;
            sleep_p <= 1'b0;
        end else if (css_s && state != ST_IDLE) begin
            dpd     <= (dpd & ~wake_p) | sleep_p;
            wake_p  <= 1'b0;
            sleep_p <= 1'b0;
        end else if (cmd_done) begin
            wake_p  <= cmd == CMD_RLS_DPD;
            sleep_p <= cmd == CMD_DPD;
        end
    assign go_rd = cmd == CMD_FAST_RD && !dpd;
    assign o_dpd = dpd;
`else
    assign go_rd = cmd == CMD_FAST_RD;
    assign o_dpd = 1'b0;
`endif

    always_ff @(posedge clk or negedge resetn)
        if (!resetn) state <= ST_IDLE;
        else         state <= state_n;

    always_comb begin
        state_n = state;
        if (css_s) state_n = ST_IDLE;
        else case (state)
            ST_IDLE:  state_n = css_fall ? ST_CMD : ST_IDLE;
            ST_CMD:   state_n = cmd_done ? (go_rd ? ST_ADDR : ST_IGNORE) : ST_CMD;
            ST_ADDR:  state_n = addr_done ? ST_DUMMY : ST_ADDR;
            ST_DUMMY: state_n = dummy_done ? ST_DATA : ST_DUMMY;
            default:  state_n = state;
        endcase
    end

    assign o_busy        = !css_s && state != ST_IDLE;
    assign o_spi_miso_oe = state == ST_DATA;

    always_ff @(posedge clk or negedge resetn)
        if (!resetn) begin
            cnt <= '0;
            sh  <= '1;
        end else begin
            cnt <= (state_n != state || state == ST_IDLE) ? '0 : cnt + {7'd0, sck_rise};
            if (sck_rise) sh <= {sh[21:0], mosi_s};
        end

    // One-deep prefetch buffer: a new fetch is only issued when the buffered byte is consumed,
    // so at most one request is ever outstanding.
    always_ff @(posedge clk or negedge resetn)
        if (!resetn) begin
            o_spi_miso <= 1'b1;
            tx         <= '1;
            bcnt       <= '0;
            rbuf       <= '0;
            rbuf_vld   <= 1'b0;
            pend       <= 1'b0;
            o_rd_req   <= 1'b0;
            o_rd_addr  <= '0;
            o_underrun <= 1'b0;
        end else begin
            o_rd_req <= 1'b0;
            if (css_fall) o_underrun <= 1'b0;
            if (state_n == ST_IDLE) begin
                o_spi_miso <= 1'b1;
                tx         <= '1;
                bcnt       <= '0;
                rbuf_vld   <= 1'b0;
                pend       <= 1'b0;
            end else begin
                if (pend && i_rd_valid) begin
                    rbuf     <= i_rd_data;
                    rbuf_vld <= 1'b1;
                    pend     <= 1'b0;
                end
                if (addr_done) begin
                    o_rd_req  <= 1'b1;
                    o_rd_addr <= addr_full[MEM_AW-1:0];
                    pend      <= 1'b1;
                end
                if (state == ST_DATA && sck_fall) begin
                    bcnt <= bcnt + 3'd1;
                    {o_spi_miso, tx} <= bcnt != 3'd0 ? {tx, 1'b1} : rbuf_vld ? {rbuf, 1'b1} : 9'h1FF;
                    if (bcnt == 3'd0 && rbuf_vld) begin
                        rbuf_vld  <= 1'b0;
                        pend      <= 1'b1;
                        o_rd_req  <= 1'b1;
                        o_rd_addr <= o_rd_addr + MEM_AW'(1);
                    end
                    if (bcnt == 3'd0 && !rbuf_vld) o_underrun <= 1'b1;
                end
            end
        end
endmodule

// File: tb/tb_spi_flash_responder.sv
// tb_spi_flash_responder: directed self-checking bench for spi_flash_responder
module tb_spi_flash_responder;
    import spi_flash_pkg::*;
    localparam int H = 5;
    logic        clk = 1'b0, resetn = 1'b0, css = 1'b1, sck = 1'b1, mosi = 1'b1;
    logic        miso, miso_oe, rd_req, rd_valid = 1'b0, busy, dpd, underrun;
    logic [23:0] rd_addr, m_addr = '0;
    logic [7:0]  rd_data = '0;
    logic [7:0]  rxb [8];
    logic [7:0]  r;
    logic [23:0] req_q [$];
    logic        oe_seen;
    int          lat = 2, m_cnt = 0, total = 0, bad = 0;

    spi_flash_responder dut (
        .clk           (clk),
        .resetn        (resetn),
        .i_spi_css     (css),
        .i_spi_clk     (sck),
        .i_spi_mosi    (mosi),
        .o_spi_miso    (miso),
        .o_spi_miso_oe (miso_oe),
        .o_rd_req      (rd_req),
        .o_rd_addr     (rd_addr),
        .i_rd_data     (rd_data),
        .i_rd_valid    (rd_valid),
        .o_busy        (busy),
        .o_dpd         (dpd),
        .o_underrun    (underrun)
    );

    always #5 clk = ~clk;

    // Memory model: returns addr[7:0] lat cycles after each request, logs every request address.
    always @(posedge clk) begin
        rd_valid <= 1'b0;
        if (rd_req) begin
            req_q.push_back(rd_addr);
            m_addr <= rd_addr;
            m_cnt  <= lat;
        end else if (m_cnt > 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) begin
                rd_valid <= 1'b1;
                rd_data  <= m_addr[7:0];
            end
        end
    end

    task automatic clk_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic spi_bit(input logic b, output logic s);
        sck  = 1'b0;
        mosi = b;
        clk_n(H);
        s       = miso;
        oe_seen = miso_oe;
        sck = 1'b1;
        clk_n(H);
    endtask

    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
        for (int i = 7; i >= 0; i--) spi_bit(tx[i], rx[i]);
    endtask

    task automatic css_low;
        css = 1'b0;
        clk_n(H);
    endtask

    task automatic css_high;
        css = 1'b1;
        clk_n(H);
    endtask

    task automatic cmd_frame(input logic [7:0] c);
        logic [7:0] x;
        css_low();
        spi_byte(c, x);
        css_high();
    endtask

    task automatic read_frame(input logic [23:0] a, input int n);
        logic [7:0] x;
        req_q.delete();
        css_low();
        spi_byte(CMD_FAST_RD, x);
        spi_byte(a[23:16], x);
        spi_byte(a[15:8], x);
        spi_byte(a[7:0], x);
        spi_byte(8'h00, x);
        for (int k = 0; k < n; k++) spi_byte(8'h00, rxb[k]);
        css_high();
    endtask

    initial begin
        logic b;
        clk_n(3);
        chk("rst_miso", miso, 1);
        chk("rst_oe", miso_oe, 0);
        chk("rst_req", rd_req, 0);
        chk("rst_addr", rd_addr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_underrun", underrun, 0);
        chk("rst_dpd", dpd, 0);
        resetn = 1'b1;
        clk_n(3);

        read_frame(24'h020000, 4);
        chk("rd_oe", oe_seen, 1);
        for (int k = 0; k < 4; k++) chk($sformatf("rd_byte%0d", k), rxb[k], k);
        chk("rd_nreq", req_q.size(), 5);
        for (int k = 0; k < 5; k++) chk($sformatf("rd_addr%0d", k), req_q[k], 24'h020000 + k);
        chk("end_busy", busy, 0);
        chk("end_oe", miso_oe, 0);
        chk("end_underrun", underrun, 0);
        clk_n(20);

        read_frame(24'hFFFFFF, 2);
        chk("wrap_b0", rxb[0], 8'hFF);
        chk("wrap_b1", rxb[1], 8'h00);
        chk("wrap_addr0", req_q[0], 24'hFFFFFF);
        chk("wrap_addr1", req_q[1], 24'h000000);
        chk("wrap_underrun", underrun, 0);
        clk_n(20);

        lat = 100;
        read_frame(24'h000055, 2);
        chk("ur_b0", rxb[0], 8'hFF);
        chk("ur_b1", rxb[1], 8'h55);
        chk("ur_flag", underrun, 1);
        clk_n(150);
        chk("ur_sticky", underrun, 1);
        lat = 2;

        req_q.delete();
        css_low();
        chk("ur_clear", underrun, 0);
        spi_byte(CMD_FAST_RD, r);
        chk("abort_busy", busy, 1);
        for (int i = 0; i < 5; i++) spi_bit(1'b1, b);
        css = 1'b1;
        clk_n(3);
        chk("abort_state", 32'(dut.state), 32'(ST_IDLE));
        chk("abort_busy_lo", busy, 0);
        clk_n(20);
        chk("abort_noreq", req_q.size(), 0);

        css_low();
        spi_byte(CMD_FAST_RD, r);
        spi_byte(8'h00, r);
        spi_byte(8'h00, r);
        spi_byte(8'h20, r);
        spi_byte(8'h00, r);
        spi_byte(8'h00, r);
        chk("mid_byte", r, 8'h20);
        chk("mid_oe", miso_oe, 1);
        resetn = 1'b0;
        clk_n(2);
        chk("mid_rst_oe", miso_oe, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_miso", miso, 1);
        resetn = 1'b1;
        clk_n(2);
        css_high();
        clk_n(20);
        read_frame(24'h000030, 2);
        chk("post_b0", rxb[0], 8'h30);
        chk("post_b1", rxb[1], 8'h31);
        chk("post_addr0", req_q[0], 24'h000030);
        clk_n(20);

`ifdef SPI_RESP_DPD_EN
        cmd_frame(CMD_DPD);
        chk("dpd_set", dpd, 1);
        read_frame(24'h000040, 1);
        chk("dpd_miso", rxb[0], 8'hFF);
        chk("dpd_oe", oe_seen, 0);
        chk("dpd_noreq", req_q.size(), 0);
        chk("dpd_hold", dpd, 1);
        cmd_frame(CMD_RLS_DPD);
        chk("dpd_wake", dpd, 0);
`else
        cmd_frame(CMD_DPD);
        chk("nodpd_b9", dpd, 0);
        cmd_frame(CMD_RLS_DPD);
        chk("nodpd_ab", dpd, 0);
`endif
        clk_n(20);
        read_frame(24'h000040, 2);
        chk("after_b0", rxb[0], 8'h40);
        chk("after_b1", rxb[1], 8'h41);
        chk("after_addr0", req_q[0], 24'h000040);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
